// File: rtl/voice_pkg.sv
// voice_pkg: shared datapath defaults and reader state encoding
package voice_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int N_BINS_DEF = 64;
  localparam int IDX_W_DEF = 6;
  typedef enum logic {IDLE, STREAM} rd_state_t;
endpackage

// File: rtl/bin_bank.sv
// bin_bank: one frame of bins with written-mask, single write port and registered zero-filling read
module bin_bank import voice_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_BINS = N_BINS_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              clr,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [N_BINS];
  logic [N_BINS-1:0] mask;
  // bin storage, contents survive reset since the mask gates them
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // clear dominates a same-cycle write so a dropped or recycled frame starts empty
  always_ff @(posedge clk or negedge rst)
    if (!rst) mask <= '0;
    else if (clr) mask <= '0;
    else if (we) mask[waddr] <= 1'b1;
  // write-through read so a bin landing on the closing edge is visible at once
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata <= '0;
    else rdata <= (we && waddr == raddr) ? wdata : mask[raddr] ? mem[raddr] : '0;
endmodule

// File: rtl/ifft_bin_collector.sv
// ifft_bin_collector: ping-pong frame buffer feeding the IFFT stage in bin order
module ifft_bin_collector import voice_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_BINS = N_BINS_DEF,
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_freq,
  input  logic              in_fin,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              overflow
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BINS - 1);
  rd_state_t state;
  logic wr_bank, fin_q, arm, close, final_hs, accept, drop, nxt_valid;
  logic [IDX_W-1:0] nxt_idx;
  logic [DATA_W-1:0] rdata [2];
  // close detection and accept/drop arbitration against the reader
  always_comb begin
    close = in_fin & ~fin_q & arm;
    final_hs = out_valid & out_ready & out_last;
    accept = close & (state == IDLE | final_hs);
    drop = close & ~accept;
    nxt_valid = accept | (out_valid & ~final_hs);
    nxt_idx = accept ? '0 : (out_valid & out_ready & ~out_last) ? out_idx + 1'b1 : out_idx;
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    bin_bank #(.DATA_W(DATA_W), .N_BINS(N_BINS), .IDX_W(IDX_W)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (in_valid & (wr_bank == 1'(b))),
      .clr   ((accept & (wr_bank != 1'(b))) | (drop & (wr_bank == 1'(b)))),
      .waddr (in_freq),
      .wdata (in_data),
      .raddr (nxt_idx),
      .rdata (rdata[b])
    );
  end
  assign out_data = rdata[~wr_bank];
  // reader FSM, bank swap and registered stream outputs; arm blocks a close until in_fin is seen low after reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      wr_bank <= 1'b0;
      fin_q <= 1'b0;
      arm <= 1'b0;
      out_valid <= 1'b0;
      out_idx <= '0;
      out_last <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= accept ? STREAM : final_hs ? IDLE : state;
      wr_bank <= wr_bank ^ accept;
      fin_q <= in_fin;
      arm <= arm | ~in_fin;
      out_valid <= nxt_valid;
      out_idx <= nxt_idx;
      out_last <= nxt_valid & (nxt_idx == LAST);
      overflow <= drop;
    end
endmodule

// File: tb/tb_ifft_bin_collector.sv
// tb_ifft_bin_collector: randomized frames checked against a queue-based frame model
module tb_ifft_bin_collector;
  logic clk = 0, rst = 1, in_valid = 0, in_fin = 0, out_ready = 0;
  logic [31:0] in_data = 0;
  logic [5:0] in_freq = 0;
  logic out_valid, out_last, overflow;
  logic [31:0] out_data;
  logic [5:0] out_idx;
  typedef struct packed {logic [5:0] idx; logic [31:0] data; logic last;} beat_t;
  beat_t q[$];
  logic [31:0] wf [64];
  bit wm [64];
  bit prev_fin, armed, exp_ovf;
  int n_cmp, n_err;

  ifft_bin_collector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_freq(in_freq),
    .in_fin(in_fin), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 64; i++) wm[i] = 0;
    prev_fin = 0;
    armed = 0;
    exp_ovf = 0;
  endtask

  task automatic model();
    bit hs, close;
    hs = q.size() > 0 && out_ready;
    close = in_fin && !prev_fin && armed;
    exp_ovf = 0;
    if (in_valid) begin
      wf[in_freq] = in_data;
      wm[in_freq] = 1;
    end
    if (hs) void'(q.pop_front());
    if (close) begin
      if (q.size() == 0)
        for (int i = 0; i < 64; i++)
          q.push_back(beat_t'{idx: 6'(i), data: wm[i] ? wf[i] : 32'h0, last: i == 63});
      else exp_ovf = 1;
      for (int i = 0; i < 64; i++) wm[i] = 0;
    end
    armed = armed | !in_fin;
    prev_fin = in_fin;
  endtask

  task automatic check();
    chk("valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("idx", out_idx, q[0].idx);
      chk("data", out_data, q[0].data);
      chk("last", out_last, q[0].last);
    end
    chk("overflow", overflow, exp_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    check();
  endtask

  task automatic send_frame(int s1, int s2, bit ramp);
    for (int f = 0; f < 64; f++) begin
      in_valid = (f != s1 && f != s2);
      in_freq = 6'(f);
      in_data = ramp ? f * 32'h00010001 : $urandom;
      in_fin = (f == 63);
      step();
    end
    in_valid = 0;
    in_fin = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    in_valid = 0;
    in_fin = 0;
    for (int k = 0; k < 200 && q.size() != 0; k++) step();
    step();
    chk("drained", out_valid, 0);
  endtask

  task automatic wait_left(int n);
    out_ready = 1;
    for (int k = 0; k < 200 && q.size() != n; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_freq = 6'($urandom);
      in_data = $urandom;
      step();
    end
    chk("wait_idx", out_idx, 64 - n);
  endtask

  initial begin
    model_reset();
    #1 rst = 0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ovf", overflow, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1;
    // ramp frame streamed with ready high
    out_ready = 1;
    send_frame(-1, -1, 1);
    drain();
    // bins 5 and 40 missing
    send_frame(5, 40, 0);
    drain();
    // ready toggling every cycle
    send_frame(-1, -1, 0);
    for (int k = 0; k < 140; k++) begin
      out_ready = 1'(k);
      step();
    end
    drain();
    // second close with 10 beats left is dropped
    send_frame(-1, -1, 0);
    wait_left(10);
    in_valid = 0;
    in_fin = 1;
    step();
    in_fin = 0;
    drain();
    // second close on the final handshake streams back-to-back
    send_frame(-1, -1, 0);
    wait_left(1);
    in_valid = 0;
    in_fin = 1;
    step();
    chk("b2b_idx", out_idx, 0);
    chk("b2b_valid", out_valid, 1);
    in_fin = 0;
    drain();
    // asynchronous reset at beat 20 with in_fin held afterwards
    send_frame(-1, -1, 0);
    wait_left(44);
    in_valid = 0;
    #1 rst = 0;
    in_fin = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_idx", out_idx, 0);
    chk("arst_last", out_last, 0);
    chk("arst_ovf", overflow, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst = 1;
    for (int k = 0; k < 6; k++) step();
    chk("held_fin_idle", out_valid, 0);
    in_fin = 0;
    in_valid = 1;
    in_freq = 6'd7;
    in_data = 32'hA5A5_0007;
    step();
    in_valid = 0;
    in_fin = 1;
    step();
    in_fin = 0;
    drain();
    // random traffic
    for (int k = 0; k < 1500; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_freq = 6'($urandom);
      in_data = $urandom;
      in_fin = ($urandom_range(0, 39) == 0) ? 1'b1 : (in_fin & 1'($urandom_range(0, 1)));
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ifft_bin_collector.md
IFFT_BIN_COLLECTOR -- requirements
Module: ifft_bin_collector

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, packed complex bin {real[31:16], imag[15:0]}; N_BINS, default 64, bins per frame; IDX_W, default 6, bin index width.
REQ-002 SHALL have ports: clk, input, 1, sole clock; all logic on its rising edge.
REQ-003 SHALL have ports: rst, input, 1, reset, asynchronous assert, active-low.
REQ-004 SHALL have ports: in_valid, input, 1, bin present on in_data/in_freq (level; may stay high).
REQ-005 SHALL have ports: in_data, input, DATA_W, phase-shifted bin from the frequency-raise stage.
REQ-006 SHALL have ports: in_freq, input, IDX_W, bin index of in_data.
REQ-007 SHALL have ports: in_fin, input, 1, frame-complete flag (high while in_freq==63).
REQ-008 SHALL have ports: out_ready, input, 1, IFFT stage accepts out_data.
REQ-009 SHALL have ports: out_valid, output, 1; out_data, output, DATA_W; out_idx, output, IDX_W; out_last, output, 1, high with idx N_BINS-1.
REQ-010 SHALL have ports: overflow, output, 1, one-cycle pulse on dropped frame.

Function
REQ-011 SHALL hold two banks of N_BINS x DATA_W storage plus one N_BINS-bit written-mask per bank (ping-pong): one write bank, one read bank.
REQ-012 SHALL, each cycle in_valid is high, write in_data to write bank[in_freq] and set its mask bit; repeated writes to same index overwrite (idempotent for level valid).
REQ-013 SHALL detect frame close as rising edge of in_fin (in_fin high, registered in_fin low); a held in_fin SHALL close only once.
REQ-014 SHALL, when in_valid and close occur in the same cycle, store that bin in the closing bank before swap.
REQ-015 SHALL run reader FSM IDLE -> STREAM -> IDLE: IDLE->STREAM on accepted close; STREAM->IDLE on out_valid & out_ready & out_last with no accepted close that cycle.
REQ-016 SHALL accept close when reader is IDLE, or in STREAM on the cycle of its final handshake (out_last & out_ready); accepted close swaps banks, clears new write-bank mask, resets read index to 0.
REQ-017 SHALL, on close not accepted, drop the write-bank frame (clear its mask, no swap), pulse overflow for exactly one cycle, leave streaming undisturbed.
REQ-018 SHALL assert out_valid on the clock edge after an accepted close (first visible cycle after in_fin rises); outputs all registered.
REQ-019 SHALL present out_data = read bank[out_idx] if its mask bit set, else 32'h0 (missing bins zero-filled).
REQ-020 SHALL hold out_data/out_idx/out_last stable while out_valid & !out_ready; advance index by one per handshake, 0..N_BINS-1, no wrap beyond N_BINS-1.
REQ-021 SHALL stream back-to-back frames with no bubble when close coincides with final handshake (next cycle out_idx=0, out_valid=1).
REQ-022 SHALL ignore in_freq values and widths outside range only by index truncation to IDX_W (no checks).

Reset
REQ-023 SHALL, on rst low, asynchronously force: out_valid=0, out_data=0, out_idx=0, out_last=0, overflow=0, FSM=IDLE, both masks=0, write bank=0, registered in_fin=0; storage contents need not reset.
REQ-024 SHALL, on reset mid-stream, abandon both frames; first post-reset output requires a fresh in_fin rising edge.

Structure
REQ-025 SHALL place DATA_W, N_BINS, IDX_W defaults and the reader FSM state encoding in shared package voice_pkg.
REQ-026 SHALL implement each bank as one sub-module instance of bin_bank (N_BINS x DATA_W, one write port, one registered read port, mask vector with clear).

Verification
REQ-027 SHALL cover: bins 0..63 with data=freq*0x00010001, in_fin at 63, out_ready=1 -> out_valid next cycle, 64 beats idx 0..63, data match, out_last only at 63.
REQ-028 SHALL cover: frame with bins 5 and 40 missing -> those beats out_data=0, others intact.
REQ-029 SHALL cover: out_ready toggled 1/0 each cycle -> outputs stable during stalls, exactly 64 handshakes, order preserved.
REQ-030 SHALL cover: second in_fin rise while 10 beats remain -> overflow one-cycle pulse, second frame absent, first completes intact.
REQ-031 SHALL cover: second close coincident with final handshake -> next cycle out_idx=0, out_valid=1, no overflow.
REQ-032 SHALL cover: rst low at beat 20 -> all outputs 0 asynchronously; held in_fin after reset produces no stream until a new rising edge.
